// File: rtl/i2s_pkg.sv
// i2s_pkg: definitions shared by the row sequencer and the i2s_mask node decoder.
//   HEADER_BITS / WORD_BITS : serial field widths
//   MAX_MODULES             : largest chain length (16 x 16)
//   seq_state_e             : row sequencer state encoding
//   hdr_pack()              : row header layout {x, y, 2'b00, row}
//   num_modules()           : chain length from the minus-one config fields
package i2s_pkg;

  localparam int HEADER_BITS = 16;
  localparam int WORD_BITS   = 16;
  localparam int MAX_MODULES = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_WORDS,
    S_STALL,
    S_GAP
  } seq_state_e;

  function automatic logic [HEADER_BITS-1:0] hdr_pack(input logic [3:0] x,
                                                      input logic [3:0] y,
                                                      input logic [5:0] row);
    return {x, y, 2'b00, row};
  endfunction

  // (x+1)*(y+1) in 9 bits: 1..256
  function automatic logic [8:0] num_modules(input logic [3:0] x,
                                             input logic [3:0] y);
    logic [8:0] a;
    logic [8:0] b;
    a = {5'd0, x} + 9'd1;
    b = {5'd0, y} + 9'd1;
    return a * b;
  endfunction

endpackage

// File: rtl/i2s_word_shifter.sv
// i2s_word_shifter: parallel-load, MSB-first shift register used for both the
// row header and the pixel words.
//   clk, rst : clock, synchronous active-high clear
//   load     : q <= din (wins over shift)
//   shift    : q <= q << 1
//   din      : parallel word
//   msb      : current serial bit (q[W-1])
module i2s_word_shifter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] q;

  always_ff @(posedge clk) begin
    if (rst)        q <= '0;
    else if (load)  q <= din;
    else if (shift) q <= {q[W-2:0], 1'b0};
  end

  assign msb = q[W-1];

endmodule

// File: rtl/i2s_row_sequencer.sv
// i2s_row_sequencer: master-side row burst generator for the LED module chain.
// Each row is a 16-bit header followed by one 16-bit pixel word per module,
// MSB first, one bit per clk while i2s_clk_en is high.
//   clk, rst            : clock, synchronous active-high reset
//   enable              : run request, looked at only at row boundaries
//   cfg_num_modules_x/y : chain geometry minus one, latched at row start
//   pix_ready/addr      : word request to the upstream buffer
//   pix_data/valid      : word return; transfer on pix_valid & pix_ready
//   i2s_data/clk_en     : serial stream and its bit-valid gate
//   row_num             : row being sent (advances at end of row)
//   busy                : not idle
//   row_done/frame_done : end-of-row / end-of-frame pulses
module i2s_row_sequencer
  import i2s_pkg::*;
#(
  parameter int NUM_ROWS   = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  cfg_num_modules_x,
  input  logic [3:0]  cfg_num_modules_y,
  output logic        pix_ready,
  output logic [7:0]  pix_addr,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        i2s_data,
  output logic        i2s_clk_en,
  output logic [5:0]  row_num,
  output logic        busy,
  output logic        row_done,
  output logic        frame_done
);

  // GAP_CYCLES=0 still spends one cycle in GAP to carry the pulses
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
  localparam logic [5:0] ROW_LAST = 6'(NUM_ROWS - 1);

  seq_state_e state, state_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [3:0]  gap_cnt, gap_cnt_n;
  logic [8:0]  n_words, n_words_n;   // words in the current row
  logic [8:0]  idx, idx_n;           // next word index to request
  logic [8:0]  loaded, loaded_n;     // words moved into the shifter so far
  logic        buf_full, buf_full_n;
  logic [15:0] buf_data;
  logic [5:0]  row_num_n;
  logic        row_done_n, frame_done_n, pix_ready_n, clk_en_n, busy_n;

  logic        sh_load, sh_shift;
  logic [15:0] sh_din;

  logic xfer, bit_last, gap_last, last_word;
  logic word_end, take_buf, take_byp, start;

  assign xfer      = pix_valid & pix_ready;
  assign bit_last  = (bit_cnt == 4'd15);
  assign gap_last  = (gap_cnt == GAP_LAST);
  assign last_word = (loaded == n_words);

  i2s_word_shifter #(.W(WORD_BITS)) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (sh_din),
    .msb   (i2s_data)
  );

  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    gap_cnt_n    = gap_cnt;
    n_words_n    = n_words;
    idx_n        = idx;
    loaded_n     = loaded;
    buf_full_n   = buf_full;
    row_num_n    = row_num;
    row_done_n   = 1'b0;
    frame_done_n = 1'b0;
    sh_load      = 1'b0;
    sh_shift     = 1'b0;
    sh_din       = '0;
    word_end     = 1'b0;
    take_buf     = 1'b0;
    take_byp     = 1'b0;
    start        = 1'b0;

    case (state)
      S_IDLE: start = enable;
      S_HEADER: begin
        bit_cnt_n = bit_cnt + 4'd1;
        if (bit_last) word_end = 1'b1;
        else          sh_shift = 1'b1;
      end
      S_WORDS: begin
        bit_cnt_n = bit_cnt + 4'd1;
        if (!bit_last) sh_shift = 1'b1;
        else if (last_word) begin
          // row complete: shifter holds, pulses and row advance go out now
          state_n      = S_GAP;
          gap_cnt_n    = '0;
          idx_n        = '0;
          row_done_n   = 1'b1;
          frame_done_n = (row_num == ROW_LAST);
          row_num_n    = (row_num == ROW_LAST) ? 6'd0 : row_num + 6'd1;
        end else word_end = 1'b1;
      end
      S_STALL: take_byp = xfer;
      S_GAP: begin
        gap_cnt_n = gap_cnt + 4'd1;
        if (gap_last) begin
          if (enable) start = 1'b1;
          else begin
            state_n = S_IDLE;
            sh_load = 1'b1;   // park i2s_data low while idle
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Next word needed: buffered word first, else a word arriving this very
    // cycle goes straight into the shifter, else wait with the bit clock off.
    if (word_end) begin
      if (buf_full)  take_buf = 1'b1;
      else if (xfer) take_byp = 1'b1;
      else           state_n  = S_STALL;
    end

    if (take_buf || take_byp) begin
      state_n  = S_WORDS;
      sh_load  = 1'b1;
      sh_din   = take_buf ? buf_data : pix_data;
      loaded_n = loaded + 9'd1;
    end

    if (xfer) begin
      idx_n = idx + 9'd1;
      if (!take_byp) buf_full_n = 1'b1;
    end
    if (take_buf) buf_full_n = 1'b0;

    if (start) begin
      state_n    = S_HEADER;
      n_words_n  = num_modules(cfg_num_modules_x, cfg_num_modules_y);
      sh_load    = 1'b1;
      sh_din     = hdr_pack(cfg_num_modules_x, cfg_num_modules_y, row_num);
      bit_cnt_n  = '0;
      idx_n      = '0;
      loaded_n   = '0;
      buf_full_n = 1'b0;
    end

    // Outputs are registered, so they are derived from next-state values.
    clk_en_n    = (state_n == S_HEADER) || (state_n == S_WORDS);
    busy_n      = (state_n != S_IDLE);
    pix_ready_n = ((state_n == S_HEADER) || (state_n == S_WORDS) || (state_n == S_STALL))
                  && !buf_full_n && (idx_n < n_words_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      n_words    <= '0;
      idx        <= '0;
      loaded     <= '0;
      buf_full   <= 1'b0;
      buf_data   <= '0;
      row_num    <= '0;
      row_done   <= 1'b0;
      frame_done <= 1'b0;
      pix_ready  <= 1'b0;
      pix_addr   <= '0;
      i2s_clk_en <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      gap_cnt    <= gap_cnt_n;
      n_words    <= n_words_n;
      idx        <= idx_n;
      loaded     <= loaded_n;
      buf_full   <= buf_full_n;
      if (xfer && !take_byp) buf_data <= pix_data;
      row_num    <= row_num_n;
      row_done   <= row_done_n;
      frame_done <= frame_done_n;
      pix_ready  <= pix_ready_n;
      pix_addr   <= idx_n[7:0];
      i2s_clk_en <= clk_en_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_i2s_row_sequencer.sv
module tb_i2s_row_sequencer;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [3:0]  cfg_num_modules_x, cfg_num_modules_y;
  logic        pix_ready;
  logic [7:0]  pix_addr;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        i2s_data, i2s_clk_en;
  logic [5:0]  row_num;
  logic        busy, row_done, frame_done;

  always #5 clk = ~clk;

  i2s_row_sequencer #(.NUM_ROWS(8), .GAP_CYCLES(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .cfg_num_modules_x (cfg_num_modules_x),
    .cfg_num_modules_y (cfg_num_modules_y),
    .pix_ready         (pix_ready),
    .pix_addr          (pix_addr),
    .pix_data          (pix_data),
    .pix_valid         (pix_valid),
    .i2s_data          (i2s_data),
    .i2s_clk_en        (i2s_clk_en),
    .row_num           (row_num),
    .busy              (busy),
    .row_done          (row_done),
    .frame_done        (frame_done)
  );

  int n_vec = 0, n_err = 0;
  bit q[$];
  int stall_cnt, held_bad, rel = 0, idle_run = 0, gap_seen, lat;
  int src_row = 0, late_addr = -1, late_rel = 0, mid_at = -1;
  logic in_row = 1'b0, last_bit = 1'b0, got_done = 1'b0, fd_at_done = 1'b0;
  logic [5:0] rn_at_done = '0;
  logic mid_en = 1'b1;
  logic [3:0] mid_x = 4'd3, mid_y = 4'd3;

  function automatic logic [15:0] pixw(input int r, input int a);
    return {r[3:0], 4'hC, a[7:0]};
  endfunction

  function automatic int outs();
    return int'({i2s_data, i2s_clk_en, pix_ready, pix_addr, row_num, busy, row_done, frame_done});
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // one clock: sample outputs after the edge, then drive the word source
  task automatic step();
    @(posedge clk); #1;
    got_done = 1'b0;
    if (row_done) begin
      in_row = 1'b0; got_done = 1'b1; fd_at_done = frame_done; rn_at_done = row_num;
    end else if (i2s_clk_en) begin
      if (!in_row) begin in_row = 1'b1; rel = 0; gap_seen = idle_run; end
      else rel++;
      q.push_back(i2s_data);
      last_bit = i2s_data;
    end else if (in_row) begin
      rel++; stall_cnt++;
      if (i2s_data !== last_bit) held_bad++;
    end
    idle_run = i2s_clk_en ? 0 : idle_run + 1;
    if (in_row && rel == mid_at) begin
      enable = mid_en; cfg_num_modules_x = mid_x; cfg_num_modules_y = mid_y;
    end
    pix_valid = !(int'(pix_addr) == late_addr && rel < late_rel);
    pix_data  = pixw(src_row, int'(pix_addr));
  endtask

  function automatic int q_hdr();
    logic [15:0] h = '0;
    for (int i = 0; i < 16 && i < q.size(); i++) h = {h[14:0], q[i]};
    return int'(h);
  endfunction

  function automatic int q_data_errs();
    int errs = 0;
    logic [15:0] w;
    for (int j = 0; j < (q.size() - 16) / 16; j++) begin
      w = '0;
      for (int b = 0; b < 16; b++) w = {w[14:0], q[16 + 16*j + b]};
      if (w !== pixw(src_row, j)) errs++;
    end
    return errs;
  endfunction

  task automatic run_row(input string tag, input int exp_hdr, input int exp_bits, input int exp_stall);
    q.delete(); stall_cnt = 0; held_bad = 0; lat = 0; got_done = 1'b0;
    for (int i = 0; i < 3000 && !got_done; i++) begin
      step();
      if (lat == 0 && q.size() != 0) lat = i + 1;
    end
    chk({tag, ".done"}, int'(got_done), 1);
    chk({tag, ".hdr"}, q_hdr(), exp_hdr);
    chk({tag, ".bits"}, q.size(), exp_bits);
    chk({tag, ".stall"}, stall_cnt, exp_stall);
    chk({tag, ".data"}, q_data_errs(), 0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; cfg_num_modules_x = 4'd3; cfg_num_modules_y = 4'd3;
    pix_valid = 1'b0; pix_data = '0;
    repeat (3) step();
    chk("reset_outs", outs(), 0);
    rst = 1'b0;
    step();
    chk("idle_outs", outs(), 0);

    // continuous frame plus one wrap row, N=16, data always on time
    enable = 1'b1;
    for (int r = 0; r < 9; r++) begin
      src_row = r % 8;
      run_row($sformatf("row%0d", r), 16'h3300 | (r % 8), 272, 0);
      if (r == 0) chk("start_lat", lat, 1);
      if (r == 1) chk("gap_len", gap_seen, 2);
      chk($sformatf("fdone%0d", r), int'(fd_at_done), int'(r % 8 == 7));
      chk($sformatf("rnum%0d", r), int'(rn_at_done), (r + 1) % 8);
    end

    // word 5 withheld until 3 cycles after it was due
    src_row = 1; late_addr = 5; late_rel = 98;
    run_row("late5", 16'h3301, 272, 3);
    late_addr = -1;

    // enable dropped mid row 2: row finishes, then idle
    src_row = 2; mid_at = 50; mid_en = 1'b0; mid_x = 4'd3; mid_y = 4'd3;
    run_row("drop", 16'h3302, 272, 0);
    mid_at = -1;
    repeat (4) step();
    chk("drop_idle", int'({busy, i2s_clk_en, pix_ready}), 0);
    chk("drop_row", int'(row_num), 3);

    // N=1 with word 0 five cycles late; config changed mid row
    cfg_num_modules_x = 4'd0; cfg_num_modules_y = 4'd0;
    src_row = 3; late_addr = 0; late_rel = 20;
    mid_at = 3; mid_en = 1'b1; mid_x = 4'd1; mid_y = 4'd0;
    enable = 1'b1;
    run_row("n1", 16'h0003, 32, 5);
    chk("n1_lat", lat, 1);
    chk("n1_held", held_bad, 0);
    mid_at = -1; late_addr = -1;

    // row 4 with new config (N=2), reset in the middle of word 1
    src_row = 4; q.delete();
    for (int i = 0; i < 200 && !(in_row && rel == 40); i++) step();
    chk("pre_rst_reached", int'(in_row && rel == 40), 1);
    chk("cfg_latched_hdr", q_hdr(), 16'h1004);
    rst = 1'b1;
    step();
    chk("rst_mid_outs", outs(), 0);
    in_row = 1'b0;
    rst = 1'b0; src_row = 0;
    run_row("after_rst", 16'h1000, 48, 0);
    chk("after_rst_lat", lat, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
